// File: rtl/iob_wishbone2iob.sv
// Wishbone B4 classic slave to IOb native master bridge.
// One registered request in flight, watchdog-terminated.
module iob_wishbone2iob #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 256,
  parameter int TIMEOUT_W = 9
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic [ADDR_W-1:0]   wb_adr_i,
  input  logic [DATA_W/8-1:0] wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic [DATA_W-1:0]   wb_dat_i,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                valid_o,
  output logic [ADDR_W-1:0]   address_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic                ready_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    TIMEOUT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [SEL_W-1:0]    wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                abort_q, abort_d;
  logic                err_q, err_d;
  logic                abort_now;
  logic                timeout_hit;
  logic                wb_req;

  assign wb_req      = wb_cyc_i & wb_stb_i;
  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  // state and datapath registers
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  // next-state and next-datapath logic
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    err_d     = err_q;
    abort_now = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wb_req) begin
          addr_d  = wb_adr_i;
          wdata_d = wb_dat_i;
          wstrb_d = wb_we_i ? wb_sel_i : '0;
          cnt_d   = '0;
          abort_d = 1'b0;
          err_d   = 1'b0;
          if (wb_we_i && (wb_sel_i == '0)) begin
            state_d = RESP;
          end else begin
            state_d = REQ;
            valid_d = 1'b1;
          end
        end
      end
      REQ: begin
        abort_now = abort_q | ~wb_cyc_i;
        abort_d   = abort_now;
        if (ready_i) begin
          valid_d = 1'b0;
          if (wstrb_q == '0) rdata_d = rdata_i;
          state_d = abort_now ? DRAIN : RESP;
        end else if (timeout_hit) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          state_d = abort_now ? DRAIN : RESP;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // a response is only shown while the master still requests it
  always_comb begin
    wb_ack_o = (state_q == RESP) & ~err_q & wb_req;
    wb_err_o = (state_q == RESP) & err_q & wb_req;
  end

  assign valid_o   = valid_q;
  assign address_o = addr_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;
  assign wb_dat_o  = rdata_q;

endmodule

// File: tb/tb_iob_wishbone2iob.sv
// Self-checking bench for iob_wishbone2iob.
// Table vectors, hand sequences, random model check.
module tb_iob_wishbone2iob;

  logic        clk = 1'b0;
  logic        arst_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        valid_o;
  logic [31:0] address_o;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic [31:0] rdata_i;
  logic        ready_i;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] last_rd;

  iob_wishbone2iob #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT(8),
    .TIMEOUT_W(9)
  ) dut (
    .clk_i(clk),
    .arst_i(arst_i),
    .wb_adr_i(wb_adr_i),
    .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o),
    .valid_o(valid_o),
    .address_o(address_o),
    .wdata_o(wdata_o),
    .wstrb_o(wstrb_o),
    .rdata_i(rdata_i),
    .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached, required finish");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] rd;
    int          rdly;
    int          ev;
    int          er;
    logic [3:0]  es;
    logic [31:0] edo;
  } vec_t;

  vec_t tbl[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // runs one Wishbone transfer; ready_i is given in valid cycle rdly
  task automatic do_xfer(
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [3:0]  sel,
    input  logic [31:0] dat,
    input  logic [31:0] rd,
    input  int          rdly,
    output int          vcyc,
    output int          rcyc,
    output logic [1:0]  resp,
    output logic [31:0] a_seen,
    output logic [31:0] d_seen,
    output logic [3:0]  s_seen,
    output logic [31:0] dato,
    output logic        unstable
  );
    vcyc = 0; rcyc = -1; resp = 2'b00;
    a_seen = '0; d_seen = '0; s_seen = '0;
    dato = '0; unstable = 1'b0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    wb_we_i = we; wb_adr_i = adr;
    wb_sel_i = sel; wb_dat_i = dat;
    rdata_i = rd; ready_i = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      ready_i = 1'b0;
      if (wb_ack_o || wb_err_o) begin
        rcyc = c;
        resp = {wb_ack_o, wb_err_o};
        dato = wb_dat_o;
        break;
      end
      if (valid_o) begin
        if (vcyc == 0) begin
          a_seen = address_o;
          d_seen = wdata_o;
          s_seen = wstrb_o;
        end else if (address_o !== a_seen ||
                     wdata_o !== d_seen ||
                     wstrb_o !== s_seen) begin
          unstable = 1'b1;
        end
        ready_i = (vcyc == rdly);
        vcyc++;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    ready_i = 1'b0; rdata_i = $urandom;
    tick();
  endtask

  int          v, r;
  logic [1:0]  resp;
  logic [31:0] as, ds, dto;
  logic [3:0]  ss;
  logic        unst;

  initial begin
    arst_i = 1'b1;
    wb_adr_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_dat_i = '0;
    rdata_i = '0; ready_i = 1'b0;
    last_rd = '0;

    tbl[0] = '{1'b0, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF,
               1, 2, 3, 4'h0, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 32'h204, 4'h6, 32'h11223344, 32'h55555555,
               0, 1, 2, 4'h6, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 32'h300, 4'h0, 32'h0000AAAA, 32'h12345678,
               0, 0, 1, 4'h0, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 32'h003, 4'hF, 32'h0, 32'hCAFEF00D,
               3, 4, 5, 4'h0, 32'hCAFEF00D};
    tbl[4] = '{1'b0, 32'h7FC, 4'h0, 32'h0, 32'h0BADC0DE,
               6, 7, 8, 4'h0, 32'h0BADC0DE};

    // reset state
    tick(); tick();
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_addr", 64'(address_o), 64'(0));
    chk("rst_wdata", 64'(wdata_o), 64'(0));
    chk("rst_wstrb", 64'(wstrb_o), 64'(0));
    chk("rst_dat", 64'(wb_dat_o), 64'(0));
    chk("rst_ack", 64'(wb_ack_o), 64'(0));
    chk("rst_err", 64'(wb_err_o), 64'(0));
    arst_i = 1'b0;
    tick();

    // table vectors
    for (int i = 0; i < 5; i++) begin
      do_xfer(tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat,
              tbl[i].rd, tbl[i].rdly, v, r, resp, as, ds, ss,
              dto, unst);
      chk($sformatf("tbl%0d_vcyc", i), 64'(v), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_ackcyc", i), 64'(r), 64'(tbl[i].er));
      chk($sformatf("tbl%0d_resp", i), 64'(resp), 64'(2'b10));
      chk($sformatf("tbl%0d_dat", i), 64'(dto), 64'(tbl[i].edo));
      chk($sformatf("tbl%0d_stable", i), 64'(unst), 64'(0));
      if (tbl[i].ev > 0) begin
        chk($sformatf("tbl%0d_addr", i), 64'(as), 64'(tbl[i].adr));
        chk($sformatf("tbl%0d_wstrb", i), 64'(ss), 64'(tbl[i].es));
        if (tbl[i].we)
          chk($sformatf("tbl%0d_wdata", i), 64'(ds), 64'(tbl[i].dat));
      end
    end
    last_rd = 32'h0BADC0DE;

    // watchdog: ready never comes
    do_xfer(1'b0, 32'h400, 4'hF, 32'h0, 32'h99999999, 1000,
            v, r, resp, as, ds, ss, dto, unst);
    chk("to_vcyc", 64'(v), 64'(8));
    chk("to_errcyc", 64'(r), 64'(9));
    chk("to_resp", 64'(resp), 64'(2'b01));
    chk("to_dat", 64'(dto), 64'(last_rd));
    ready_i = 1'b1;
    rdata_i = 32'h77777777;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("late_valid", 64'(valid_o), 64'(0));
      chk("late_dat", 64'(wb_dat_o), 64'(last_rd));
    end
    ready_i = 1'b0;
    tick();

    // abort: cyc dropped in REQ, ready late
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = 32'h500; rdata_i = 32'h13579BDF;
    for (int c = 1; c <= 9; c++) begin
      tick();
      ready_i = 1'b0;
      if (c <= 5)
        chk($sformatf("ab_valid_c%0d", c), 64'(valid_o), 64'(1));
      if (c == 3) wb_cyc_i = 1'b0;
      if (c == 5) begin
        ready_i = 1'b1;
        wb_cyc_i = 1'b1;
        wb_adr_i = 32'h504;
        rdata_i = 32'h2468ACE0;
      end
      if (c == 6 || c == 7) begin
        chk($sformatf("ab_valid_c%0d", c), 64'(valid_o), 64'(0));
        chk($sformatf("ab_resp_c%0d", c),
            64'({wb_ack_o, wb_err_o}), 64'(0));
      end
      if (c == 8) begin
        chk("ab_new_valid", 64'(valid_o), 64'(1));
        chk("ab_new_addr", 64'(address_o), 64'(32'h504));
        ready_i = 1'b1;
      end
      if (c == 9) begin
        chk("ab_new_ack", 64'({wb_ack_o, wb_err_o}), 64'(2'b10));
        chk("ab_new_dat", 64'(wb_dat_o), 64'(32'h2468ACE0));
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; ready_i = 1'b0;
    last_rd = 32'h2468ACE0;
    tick();

    // back-to-back reads, stb held, ready always high
    begin
      logic [31:0] ba[4];
      logic [31:0] br[4];
      int acks, vals, lastack;
      logic pv;
      for (int k = 0; k < 4; k++) begin
        ba[k] = $urandom;
        br[k] = $urandom;
      end
      acks = 0; vals = 0; pv = 1'b0; lastack = -1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
      wb_adr_i = ba[0]; rdata_i = br[0]; ready_i = 1'b1;
      for (int c = 1; c <= 12; c++) begin
        tick();
        if (valid_o && !pv) begin
          if (vals < 4)
            chk("b2b_addr", 64'(address_o), 64'(ba[vals]));
          vals++;
        end
        pv = valid_o;
        if (wb_ack_o) begin
          if (acks < 4)
            chk("b2b_dat", 64'(wb_dat_o), 64'(br[acks]));
          acks++;
          lastack = c;
          if (acks < 4) begin
            wb_adr_i = ba[acks];
            rdata_i = br[acks];
          end else begin
            wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
          end
        end
      end
      chk("b2b_acks", 64'(acks), 64'(4));
      chk("b2b_valids", 64'(vals), 64'(4));
      chk("b2b_lastack", 64'(lastack), 64'(11));
      last_rd = br[3];
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; ready_i = 1'b0;
      tick();
    end

    // random transfers against the behavioural model
    for (int i = 0; i < 40; i++) begin
      logic        we;
      logic [3:0]  sel;
      logic [31:0] adr, dat, rd;
      int          dly, ev, er;
      logic        zs;
      logic [31:0] edo;
      we  = 1'($urandom);
      sel = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      adr = $urandom; dat = $urandom; rd = $urandom;
      dly = $urandom_range(0, 5);
      zs  = we && (sel == 4'h0);
      ev  = zs ? 0 : dly + 1;
      er  = zs ? 1 : dly + 2;
      edo = we ? last_rd : rd;
      do_xfer(we, adr, sel, dat, rd, dly, v, r, resp,
              as, ds, ss, dto, unst);
      chk("rnd_vcyc", 64'(v), 64'(ev));
      chk("rnd_ackcyc", 64'(r), 64'(er));
      chk("rnd_resp", 64'(resp), 64'(2'b10));
      chk("rnd_dat", 64'(dto), 64'(edo));
      chk("rnd_stable", 64'(unst), 64'(0));
      if (!zs) begin
        chk("rnd_addr", 64'(as), 64'(adr));
        chk("rnd_wstrb", 64'(ss), 64'(we ? sel : 4'h0));
        if (we) chk("rnd_wdata", 64'(ds), 64'(dat));
      end
      last_rd = edo;
    end

    // reset in the middle of a request
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_sel_i = 4'hF; wb_adr_i = 32'h600; wb_dat_i = 32'hA5A5A5A5;
    tick();
    chk("mr_valid_pre", 64'(valid_o), 64'(1));
    arst_i = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick();
    arst_i = 1'b0;
    chk("mr_valid", 64'(valid_o), 64'(0));
    chk("mr_addr", 64'(address_o), 64'(0));
    chk("mr_wdata", 64'(wdata_o), 64'(0));
    chk("mr_wstrb", 64'(wstrb_o), 64'(0));
    chk("mr_dat", 64'(wb_dat_o), 64'(0));
    ready_i = 1'b1;
    tick();
    chk("mr_valid_post", 64'(valid_o), 64'(0));
    ready_i = 1'b0;
    do_xfer(1'b0, 32'h700, 4'h0, 32'h0, 32'h600DF00D, 2,
            v, r, resp, as, ds, ss, dto, unst);
    chk("mr_rd_vcyc", 64'(v), 64'(3));
    chk("mr_rd_ackcyc", 64'(r), 64'(4));
    chk("mr_rd_resp", 64'(resp), 64'(2'b10));
    chk("mr_rd_dat", 64'(dto), 64'(32'h600DF00D));
    chk("mr_rd_addr", 64'(as), 64'(32'h700));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iob_wishbone2iob.md
Name: iob_wishbone2iob

Overview:
Wishbone B4 classic-cycle slave to IOb native master bridge; the inverse of the IOb-to-Wishbone bridge. It lets a Wishbone master, such as the ethmac DMA port, access IOb memories and peripherals. It registers each Wishbone request, issues it on IOb, waits for ready, and returns a one-cycle ack or err. A watchdog terminates requests the IOb side never completes.

Parameters:
ADDR_W, 32, address width (byte address, passed through unchanged)
DATA_W, 32, data width; select/strobe width is DATA_W/8
TIMEOUT, 256, max cycles valid_o is held waiting for ready_i before err; 0 disables the watchdog
TIMEOUT_W, 9, watchdog counter width; must hold TIMEOUT

Ports:
clk_i  in  1  clock
arst_i  in  1  reset; synchronous, active-high
wb_adr_i  in  ADDR_W  Wishbone byte address
wb_sel_i  in  DATA_W/8  byte select
wb_we_i  in  1  write enable
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_dat_i  in  DATA_W  write data
wb_dat_o  out  DATA_W  read data, valid while wb_ack_o=1
wb_ack_o  out  1  normal termination
wb_err_o  out  1  error termination (timeout)
valid_o  out  1  IOb request valid
address_o  out  ADDR_W  IOb address
wdata_o  out  DATA_W  IOb write data
wstrb_o  out  DATA_W/8  IOb write strobe; 0 means read
rdata_i  in  DATA_W  IOb read data, sampled when ready_i=1
ready_i  in  1  IOb completion

Behaviour:
- Reset, with arst_i sampled at a clock edge: FSM=IDLE; all outputs 0; watchdog=0. Reset asserted mid-transfer drops valid_o on the next edge, and no ack or err is issued.
- FSM states are IDLE, REQ, RESP and DRAIN.
- IDLE: when wb_cyc_i&wb_stb_i=1, register address, wdata, and wstrb (wb_we_i ? wb_sel_i : 0). Next state is REQ with valid_o=1.
- IDLE, zero-select write (wb_we_i=1, wb_sel_i=0): issue no IOb access; go to RESP with ack=1 on the next cycle.
- REQ: hold valid_o and the registered outputs stable until ready_i=1. In the ready cycle, capture rdata_i into wb_dat_o for reads (writes leave wb_dat_o unchanged). Next cycle: valid_o=0, state=RESP, wb_ack_o=1.
- REQ, watchdog: the counter increments each REQ cycle without ready_i. When it reaches TIMEOUT-1 with no ready_i, drop valid_o, go to RESP with wb_err_o=1, and do not update wb_dat_o. A ready_i arriving later is ignored in IDLE.
- REQ, abort: if wb_cyc_i=0 is sampled in REQ, the IOb access still completes (IOb cannot cancel). On ready_i or timeout, go to DRAIN instead of RESP. DRAIN lasts one cycle with no ack or err, then goes to IDLE.
- RESP: wb_ack_o or wb_err_o is high for exactly one cycle. They are never high together. They are never asserted unless wb_cyc_i&wb_stb_i=1 in that cycle; if either is low, suppress the response. Next state is IDLE.
- Back-to-back: a request sampled in the cycle after RESP is accepted. Minimum throughput is one transfer per 3 cycles (IDLE, REQ, RESP).
- Latency: request sampled at edge 0 gives valid_o=1 after edge 0. With ready_i=1 in that same cycle, wb_ack_o=1 after edge 1. Ack follows ready_i by one cycle.
- ready_i outside REQ is ignored. The address passes through unaligned; wb_sel_i is ignored for reads.
- wb_dat_o holds its last read value between transfers.

Test Plan:
- Read addr 0x100, rdata_i=0xDEADBEEF, ready_i one cycle after valid_o rises -> valid_o high 2 cycles, wstrb_o=0, address_o=0x100, wb_ack_o pulse 1 cycle, wb_dat_o=0xDEADBEEF.
- Write addr 0x204, sel=4'b0110, dat=0x11223344, ready_i immediate -> wstrb_o=4'b0110, wdata_o=0x11223344, ack 2 cycles after request sample; zero-sel write -> ack, valid_o never rises.
- Back-to-back reads, stb held high, 4 transfers -> 4 ack pulses, one valid_o per transfer, no transfer lost or duplicated, 12 cycles total with immediate ready.
- TIMEOUT=8, ready_i never asserted -> valid_o high 8 cycles, then wb_err_o pulse, wb_ack_o=0, wb_dat_o unchanged; a late ready_i has no effect.
- wb_cyc_i dropped 2 cycles into REQ, ready_i at cycle 5 -> valid_o stays high until ready_i, no ack/err, FSM back in IDLE 2 cycles later.
- arst_i pulsed during REQ -> all outputs 0 next cycle; a subsequent read completes normally.
